// File: rtl/reg_path_checker_pkg.sv
// Shared types and constants for reg_path_checker: FSM states, LFSR seed/taps
// and the "no error yet" marker.
package reg_path_checker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 15,13,12,10 realise x^16+x^14+x^13+x^11+1 in Fibonacci form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] NO_ERR    = 16'hFFFF;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reg_path_checker_lfsr16.sv
// 16-bit Fibonacci stimulus LFSR with synchronous seed load and advance enable.
module lfsr16
  import reg_path_checker_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      state <= LFSR_SEED;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/reg_path_checker.sv
// Stimulus/capture checker for an extracted register-to-register path.
// Optional macro REG_PATH_CHECKER_STOP_ON_ERR_EN: abort the run on the first mismatch.
module reg_path_checker
  import reg_path_checker_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 2,
  parameter int INVERT  = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [15:0]      num_cycles,
  output logic [WIDTH-1:0] stim,
  input  logic [WIDTH-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err
);

  localparam logic [3:0] DRAIN_LAST = 4'(LATENCY - 1);

  state_t            state_q;
  state_t            state_d;
  logic [15:0]       num_q;
  logic [15:0]       sample_idx;
  logic [3:0]        drain_cnt;
  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_d;
  logic              lfsr_load;
  logic              lfsr_adv;
  logic              unused_lfsr;
  logic              active;
  logic              start_ok;
  logic              mismatch;
  logic [WIDTH-1:0]  exp_resp;

  logic [LATENCY-1:0] dl_valid;
  logic [WIDTH-1:0]   dl_stim [LATENCY];
  logic [15:0]        dl_idx  [LATENCY];

  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign start_ok  = start && !active;
  assign exp_resp  = (INVERT != 0) ? ~dl_stim[LATENCY-1] : dl_stim[LATENCY-1];
  assign mismatch  = active && dl_valid[LATENCY-1] && (resp != exp_resp);
  assign pass      = done && (err_count == 16'd0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (num_cycles == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (sample_idx == num_q - 16'd1) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef REG_PATH_CHECKER_STOP_ON_ERR_EN
    if (mismatch) begin
      state_d = DONE;
    end
`endif
  end

  // stim is registered, so it is fed from the LFSR value the next cycle will hold
  assign lfsr_load   = start_ok && (state_d == RUN);
  assign lfsr_adv    = (state_q == RUN) && (state_d == RUN);
  assign lfsr_d      = lfsr_load ? LFSR_SEED :
                       lfsr_adv  ? lfsr_step(lfsr_q) : lfsr_q;
  assign unused_lfsr = ^lfsr_d;

  lfsr16 u_lfsr (
    .clk     (CLK),
    .reset   (RESET),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .state   (lfsr_q)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= 16'd0;
      first_err  <= NO_ERR;
      num_q      <= 16'd0;
      sample_idx <= 16'd0;
      drain_cnt  <= 4'd0;
      dl_valid   <= '0;
    end else begin
      stim <= (state_d == RUN) ? lfsr_d[WIDTH-1:0] : '0;
      busy <= (state_d == RUN) || (state_d == DRAIN);
      done <= (state_d == DONE);

      // Valids flush outside RUN/DRAIN so an aborted run never leaks into the next
      if (active) begin
        dl_valid[0] <= (state_q == RUN);
        for (int i = 1; i < LATENCY; i++) begin
          dl_valid[i] <= dl_valid[i-1];
        end
      end else begin
        dl_valid <= '0;
      end

      if (start_ok) begin
        err_count  <= 16'd0;
        first_err  <= NO_ERR;
        sample_idx <= 16'd0;
        drain_cnt  <= 4'd0;
        num_q      <= num_cycles;
      end else begin
        if (state_q == RUN) begin
          sample_idx <= sample_idx + 16'd1;
        end
        if (state_q == DRAIN) begin
          drain_cnt <= drain_cnt + 4'd1;
        end
        if (mismatch) begin
          if (err_count != NO_ERR) begin
            err_count <= err_count + 16'd1;
          end
          if (first_err == NO_ERR) begin
            first_err <= dl_idx[LATENCY-1];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    dl_stim[0] <= stim;
    dl_idx[0]  <= sample_idx;
    for (int i = 1; i < LATENCY; i++) begin
      dl_stim[i] <= dl_stim[i-1];
      dl_idx[i]  <= dl_idx[i-1];
    end
  end

endmodule

// File: tb/tb_reg_path_checker.sv
// Self-checking bench for reg_path_checker driving a two-flop path model
// (with or without inverter, optional single bit flip) from a vector table.
module tb_reg_path_checker;

  typedef struct {
    int n;
    bit inv;
    int flip_idx;
    int poke_at;
    int exp_err;
    int exp_first;
    bit exp_pass;
    int exp_done;
    int exp_samples;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [15:0] num_cycles;
  logic [0:0]  stim;
  logic [0:0]  resp;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [15:0] first_err;

  logic        p1;
  logic        p2;
  logic        inv_path;
  logic        flip;

  int          n_checks;
  int          n_fail;
  logic [15:0] model_lfsr;
  logic [0:0]  exp_q [$];
  vec_t        vecs [7];

  always #5 CLK = ~CLK;

  reg_path_checker #(
    .WIDTH   (1),
    .LATENCY (2),
    .INVERT  (1)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (start),
    .num_cycles (num_cycles),
    .stim       (stim),
    .resp       (resp),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_err  (first_err)
  );

  // Path under test: launch flop, optional inverter, capture flop
  always @(posedge CLK) begin
    p1 <= stim[0] ^ flip;
    p2 <= inv_path ? ~p1 : p1;
  end
  assign resp = p2;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    inv_path   = v.inv;
    flip       = 1'b0;
    start      = 1'b1;
    num_cycles = 16'(v.n);
    model_lfsr = 16'hACE1;
    for (int k = 0; k < v.exp_samples; k++) begin
      exp_q.push_back(model_lfsr[0:0]);
      model_lfsr = {model_lfsr[14:0],
                    model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
    end
  endtask

  task automatic runVector(input vec_t v, input int id);
    logic [0:0] e;
    applyStimulus(v);
    for (int c = 1; c <= v.exp_done + 1; c++) begin
      @(negedge CLK);
      start = (c == v.poke_at);
      if (c == v.poke_at) num_cycles = 16'd3;
      flip = (c - 1 == v.flip_idx);
      if (c == 1) checkOutput($sformatf("v%0d busy_first", id), {31'b0, busy}, {31'b0, v.n > 0});
      if (c <= v.exp_samples) begin
        if (exp_q.size() == 0) begin
          checkOutput($sformatf("v%0d scoreboard_empty", id), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("v%0d stim[%0d]", id, c - 1), {31'b0, stim}, {31'b0, e});
        end
      end else if (c == v.exp_samples + 1) begin
        checkOutput($sformatf("v%0d stim_idle", id), {31'b0, stim}, 32'd0);
      end
      if (c == v.exp_done - 1) checkOutput($sformatf("v%0d done_early", id), {31'b0, done}, 32'd0);
      if (c == v.exp_done) begin
        checkOutput($sformatf("v%0d done", id), {31'b0, done}, 32'd1);
        checkOutput($sformatf("v%0d pass", id), {31'b0, pass}, {31'b0, v.exp_pass});
      end
    end
    start = 1'b0;
    flip  = 1'b0;
    checkOutput($sformatf("v%0d done_held", id), {31'b0, done}, 32'd1);
    checkOutput($sformatf("v%0d err_count", id), {16'b0, err_count}, 32'(v.exp_err));
    checkOutput($sformatf("v%0d first_err", id), {16'b0, first_err}, 32'(v.exp_first));
    exp_q.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " stim"},      {31'b0, stim},      32'd0);
    checkOutput({tag, " busy"},      {31'b0, busy},      32'd0);
    checkOutput({tag, " done"},      {31'b0, done},      32'd0);
    checkOutput({tag, " pass"},      {31'b0, pass},      32'd0);
    checkOutput({tag, " err_count"}, {16'b0, err_count}, 32'd0);
    checkOutput({tag, " first_err"}, {16'b0, first_err}, 32'hFFFF);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rv;
    n_checks   = 0;
    n_fail     = 0;
    RESET      = 1'b1;
    start      = 1'b0;
    num_cycles = 16'd0;
    inv_path   = 1'b1;
    flip       = 1'b0;

    //           n    inv   flip poke err  first     pass  done samples
    vecs[0] = '{100, 1'b1,  -1,  -1,  0, 16'hFFFF, 1'b1, 103, 100};
    vecs[3] = '{  0, 1'b1,  -1,  -1,  0, 16'hFFFF, 1'b1,   1,   0};
    vecs[4] = '{  1, 1'b1,  -1,  -1,  0, 16'hFFFF, 1'b1,   4,   1};
    vecs[6] = '{ 20, 1'b1,  -1,   5,  0, 16'hFFFF, 1'b1,  23,  20};
`ifdef REG_PATH_CHECKER_STOP_ON_ERR_EN
    vecs[1] = '{100, 1'b0,  -1,  -1,  1, 0,        1'b0,   4,   3};
    vecs[2] = '{100, 1'b1,  37,  -1,  1, 37,       1'b0,  41,  40};
    vecs[5] = '{  5, 1'b0,  -1,  -1,  1, 0,        1'b0,   4,   3};
`else
    vecs[1] = '{100, 1'b0,  -1,  -1, 100, 0,       1'b0, 103, 100};
    vecs[2] = '{100, 1'b1,  37,  -1,  1, 37,       1'b0, 103, 100};
    vecs[5] = '{  5, 1'b0,  -1,  -1,  5, 0,        1'b0,   8,   5};
`endif

    repeat (3) @(negedge CLK);
    checkResetValues("reset");
    RESET = 1'b0;
    @(negedge CLK);
    checkResetValues("idle");

    for (int i = 0; i < 7; i++) begin
      runVector(vecs[i], i);
    end

    // Reset in the middle of a failing run, then confirm a clean rerun from the seed
    rv = '{100, 1'b0, -1, -1, 0, 0, 1'b0, 0, 0};
    applyStimulus(rv);
    for (int c = 1; c <= 50; c++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    checkOutput("err_before_reset", {31'b0, err_count != 16'd0}, 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    checkResetValues("midrun_reset");
    repeat (3) @(negedge CLK);
    checkResetValues("after_reset_idle");
    runVector(vecs[0], 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
